// File: rtl/cac_key_loader_24k.sv
// cac_key_loader_24k: bit-serial key delivery front end for the 24-key
// CAC-locked c432 cores. A frame is KEY_W key bits (LSB first) followed by
// check bits. A decoy key is driven until a frame passes its check.
// Repeated failures lock the loader until reset.
// Optional feature macro: KEY_CRC_EN selects an 8-bit CRC-8 (poly 0x07)
// check instead of the default single even-parity bit.
module cac_key_loader_24k #(
  parameter int               KEY_W     = 24,
  parameter int               MAX_FAIL  = 3,
  parameter logic [KEY_W-1:0] DECOY_KEY = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_sdi,
  input  logic             sdi_valid,
  output logic [KEY_W-1:0] keyinput,
  output logic             key_busy,
  output logic             key_ready,
  output logic             key_err,
  output logic             key_locked
);

  localparam int               CNT_W    = $clog2(KEY_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W - 1);
  localparam logic [3:0]       FAIL_LIM = 4'(MAX_FAIL);

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, DONE, ERR, LOCKED} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] bit_cnt;
  logic [KEY_W-1:0] shadow;
  logic [3:0]       fail_cnt;
  logic [3:0]       fail_nxt;
  logic             start_take;
  logic             shift_en;
  logic             chk_en;
  logic             chk_last;
  logic             chk_last_bit;
  logic             chk_ok;

`ifdef KEY_CRC_EN
  logic [7:0] crc_acc;
  logic [2:0] chk_cnt;
  logic       chk_mis;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // Check bits arrive crc[7] first; any earlier mismatch poisons the frame.
  assign chk_ok       = !chk_mis && (key_sdi == crc_acc[3'd7 - chk_cnt]);
  assign chk_last_bit = (chk_cnt == 3'd7);
`else
  logic par_acc;

  assign chk_ok       = (key_sdi == par_acc);
  assign chk_last_bit = 1'b1;
`endif

  assign fail_nxt   = fail_cnt + 4'd1;
  assign key_busy   = (state == SHIFT) || (state == CHECK);
  assign key_locked = (state == LOCKED);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode and per-cycle strobes for the datapath.
  always_comb begin
    state_n    = state;
    start_take = 1'b0;
    shift_en   = 1'b0;
    chk_en     = 1'b0;
    chk_last   = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (key_start) begin
          state_n    = SHIFT;
          start_take = 1'b1;
        end
      end
      SHIFT: begin
        if (sdi_valid) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_n = CHECK;
        end
      end
      CHECK: begin
        if (sdi_valid) begin
          chk_en = 1'b1;
          if (chk_last_bit) begin
            chk_last = 1'b1;
            if (chk_ok)                state_n = DONE;
            else if (fail_nxt >= FAIL_LIM) state_n = LOCKED;
            else                       state_n = ERR;
          end
        end
      end
      LOCKED:  state_n = LOCKED;
      default: state_n = IDLE;
    endcase
  end

  // Control: counters, status flags and the exposed key bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      keyinput  <= DECOY_KEY;
      key_ready <= 1'b0;
      key_err   <= 1'b0;
      fail_cnt  <= 4'd0;
      bit_cnt   <= '0;
`ifdef KEY_CRC_EN
      chk_cnt   <= 3'd0;
      chk_mis   <= 1'b0;
`endif
    end else begin
      if (start_take) begin
        bit_cnt <= '0;
        key_err <= 1'b0;
`ifdef KEY_CRC_EN
        chk_cnt <= 3'd0;
        chk_mis <= 1'b0;
`endif
      end
      if (shift_en) bit_cnt <= bit_cnt + CNT_W'(1);
`ifdef KEY_CRC_EN
      if (chk_en) begin
        chk_cnt <= chk_cnt + 3'd1;
        chk_mis <= !chk_ok;
      end
`endif
      if (chk_last) begin
        if (chk_ok) begin
          keyinput  <= shadow;
          key_ready <= 1'b1;
          fail_cnt  <= 4'd0;
        end else begin
          keyinput  <= DECOY_KEY;
          key_ready <= 1'b0;
          key_err   <= 1'b1;
          fail_cnt  <= fail_nxt;
        end
      end
    end
  end

  // Data: hidden shadow key and running check value, cleared on each start.
  always_ff @(posedge clk) begin
    if (start_take) begin
      shadow <= '0;
`ifdef KEY_CRC_EN
      crc_acc <= 8'h00;
`else
      par_acc <= 1'b0;
`endif
    end else if (shift_en) begin
      shadow <= {key_sdi, shadow[KEY_W-1:1]};
`ifdef KEY_CRC_EN
      crc_acc <= crc8_step(crc_acc, key_sdi);
`else
      par_acc <= par_acc ^ key_sdi;
`endif
    end
  end

endmodule
